// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller with minimum/maximum green, timed yellow
// and optional all-red clearance. Lamp outputs are a pure decode of the state.
module traffic_light_ctrl #(
    parameter int GREEN_MIN     = 4,
    parameter int GREEN_MAX     = 8,
    parameter int YELLOW_CYCLES = 2,
    parameter int RED_CYCLES    = 1,
    parameter int CNT_W         = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       EWCar,
    input  logic       NSCar,
    output logic [2:0] NSLite,
    output logic [2:0] EWLite,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_GREEN   = 3'd0,
        NS_YELLOW  = 3'd1,
        NS_RED_CLR = 3'd2,
        EW_GREEN   = 3'd3,
        EW_YELLOW  = 3'd4,
        EW_RED_CLR = 3'd5
    } state_t;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    // Terminal timer values; a phase left at N-1 lasts exactly N cycles.
    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] RED_LAST  = CNT_W'((RED_CYCLES > 0) ? RED_CYCLES - 1 : 0);
    localparam bit               SKIP_RED  = (RED_CYCLES == 0);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_timer;
    logic             w_green;
    logic             w_ns_exit;
    logic             w_ew_exit;

    assign w_green = (r_state == NS_GREEN) || (r_state == EW_GREEN);

    // Green ends only when the other road waits: early if own road is idle,
    // otherwise once the maximum green has been served.
    always_comb begin
        w_ns_exit = EWCar && (((r_timer >= GMIN_LAST) && !NSCar) || (r_timer >= GMAX_LAST));
        w_ew_exit = NSCar && (((r_timer >= GMIN_LAST) && !EWCar) || (r_timer >= GMAX_LAST));
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            NS_GREEN: begin
                if (w_ns_exit) w_next = NS_YELLOW;
            end
            NS_YELLOW: begin
                if (r_timer == YEL_LAST) begin
                    if (SKIP_RED) w_next = EW_GREEN;
                    else          w_next = NS_RED_CLR;
                end
            end
            NS_RED_CLR: begin
                if (r_timer == RED_LAST) w_next = EW_GREEN;
            end
            EW_GREEN: begin
                if (w_ew_exit) w_next = EW_YELLOW;
            end
            EW_YELLOW: begin
                if (r_timer == YEL_LAST) begin
                    if (SKIP_RED) w_next = NS_GREEN;
                    else          w_next = EW_RED_CLR;
                end
            end
            EW_RED_CLR: begin
                if (r_timer == RED_LAST) w_next = NS_GREEN;
            end
            default: w_next = NS_GREEN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= NS_GREEN;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_timer <= '0;
            else if (w_green && (r_timer >= GMAX_LAST))
                r_timer <= GMAX_LAST;
            else
                r_timer <= r_timer + 1'b1;
        end
    end

    always_comb begin
        NSLite = LAMP_RED;
        EWLite = LAMP_RED;
        phase  = r_state;
        case (r_state)
            NS_GREEN:  NSLite = LAMP_GREEN;
            NS_YELLOW: NSLite = LAMP_YELLOW;
            EW_GREEN:  EWLite = LAMP_GREEN;
            EW_YELLOW: EWLite = LAMP_YELLOW;
            default: begin
                NSLite = LAMP_RED;
                EWLite = LAMP_RED;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: default build plus a build with no
// all-red phase and one-cycle yellow.
module tb_traffic_light_ctrl;

    logic       clock = 1'b0;
    logic       reset, EWCar, NSCar;
    logic [2:0] NSLite, EWLite, phase;
    logic       reset2, EWCar2, NSCar2;
    logic [2:0] NSLite2, EWLite2, phase2;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    traffic_light_ctrl dut (
        .clock (clock),
        .reset (reset),
        .EWCar (EWCar),
        .NSCar (NSCar),
        .NSLite(NSLite),
        .EWLite(EWLite),
        .phase (phase)
    );

    traffic_light_ctrl #(
        .GREEN_MIN    (4),
        .GREEN_MAX    (8),
        .YELLOW_CYCLES(1),
        .RED_CYCLES   (0),
        .CNT_W        (4)
    ) dut2 (
        .clock (clock),
        .reset (reset2),
        .EWCar (EWCar2),
        .NSCar (NSCar2),
        .NSLite(NSLite2),
        .EWLite(EWLite2),
        .phase (phase2)
    );

    function automatic logic [2:0] ns_lamp(input int p);
        if (p == 0) return 3'b001;
        if (p == 1) return 3'b010;
        return 3'b100;
    endfunction

    function automatic logic [2:0] ew_lamp(input int p);
        if (p == 3) return 3'b001;
        if (p == 4) return 3'b010;
        return 3'b100;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input logic ew, input logic ns);
        reset = 1'b1;
        EWCar = ew;
        NSCar = ns;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int exp_ph[7] = '{0, 0, 0, 1, 1, 2, 3};
        reset = 1'b1;
        EWCar = 1'b1;
        NSCar = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (NSLite !== 3'b001 || EWLite !== 3'b100 || phase !== 3'd0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got ns=%b ew=%b ph=%0d want ns=001 ew=100 ph=0",
                         i, NSLite, EWLite, phase);
            end
        end
        reset = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            total++;
            if (phase !== 3'(exp_ph[k]) || NSLite !== ns_lamp(exp_ph[k]) || EWLite !== ew_lamp(exp_ph[k])) begin
                bad++;
                $display("FAIL reset_release edge=%0d got ph=%0d ns=%b ew=%b want ph=%0d ns=%b ew=%b",
                         k + 1, phase, NSLite, EWLite, exp_ph[k], ns_lamp(exp_ph[k]), ew_lamp(exp_ph[k]));
            end
        end
    endtask

    // Both roads busy: 8 green, 2 yellow, 1 red per road, period 22.
    task automatic test_both_busy();
        int m, ep;
        do_reset(1'b1, 1'b1);
        total++;
        if (phase !== 3'd0) begin
            bad++;
            $display("FAIL both_start got ph=%0d want 0", phase);
        end
        for (int k = 1; k <= 44; k++) begin
            step();
            m = k % 22;
            if (m <= 7)       ep = 0;
            else if (m <= 9)  ep = 1;
            else if (m == 10) ep = 2;
            else if (m <= 18) ep = 3;
            else if (m <= 20) ep = 4;
            else              ep = 5;
            total++;
            if (phase !== 3'(ep) || NSLite !== ns_lamp(ep) || EWLite !== ew_lamp(ep)) begin
                bad++;
                $display("FAIL both_busy edge=%0d got ph=%0d ns=%b ew=%b want ph=%0d",
                         k, phase, NSLite, EWLite, ep);
            end
        end
    endtask

    // NS holds green with no EW demand; a late one-cycle pulse ends it at once.
    task automatic test_hold_late();
        int exp_ph[4] = '{1, 1, 2, 3};
        do_reset(1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            step();
            total++;
            if (phase !== 3'd0 || NSLite !== 3'b001) begin
                bad++;
                $display("FAIL hold_green edge=%0d got ph=%0d ns=%b want ph=0 ns=001", k, phase, NSLite);
            end
        end
        EWCar = 1'b1;
        step();
        EWCar = 1'b0;
        total++;
        if (phase !== 3'(exp_ph[0])) begin
            bad++;
            $display("FAIL late_arrival got ph=%0d want %0d", phase, exp_ph[0]);
        end
        for (int k = 1; k < 4; k++) begin
            step();
            total++;
            if (phase !== 3'(exp_ph[k])) begin
                bad++;
                $display("FAIL no_abort step=%0d got ph=%0d want %0d", k, phase, exp_ph[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        int exp_ph[4] = '{0, 0, 0, 1};
        do_reset(1'b1, 1'b0);
        for (int k = 0; k < 7; k++) step();
        total++;
        if (phase !== 3'd3) begin
            bad++;
            $display("FAIL async_reach_ew got ph=%0d want 3", phase);
        end
        EWCar = 1'b0;
        NSCar = 1'b1;
        for (int k = 0; k < 4; k++) step();
        total++;
        if (phase !== 3'd4 || EWLite !== 3'b010) begin
            bad++;
            $display("FAIL async_reach_ewy got ph=%0d ew=%b want ph=4 ew=010", phase, EWLite);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (phase !== 3'd0 || NSLite !== 3'b001 || EWLite !== 3'b100) begin
            bad++;
            $display("FAIL async_assert got ph=%0d ns=%b ew=%b want ph=0 ns=001 ew=100",
                     phase, NSLite, EWLite);
        end
        EWCar = 1'b1;
        NSCar = 1'b0;
        step();
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if (phase !== 3'(exp_ph[k])) begin
                bad++;
                $display("FAIL async_min_restart edge=%0d got ph=%0d want %0d", k + 1, phase, exp_ph[k]);
            end
        end
    endtask

    task automatic test_no_red();
        int exp_ph[10] = '{0, 0, 0, 1, 3, 3, 3, 3, 4, 0};
        reset2 = 1'b1;
        EWCar2 = 1'b1;
        NSCar2 = 1'b0;
        step();
        step();
        reset2 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if (phase2 !== 3'(exp_ph[k]) || NSLite2 !== ns_lamp(exp_ph[k]) || EWLite2 !== ew_lamp(exp_ph[k])) begin
                bad++;
                $display("FAIL no_red edge=%0d got ph=%0d ns=%b ew=%b want ph=%0d",
                         k + 1, phase2, NSLite2, EWLite2, exp_ph[k]);
            end
            if (k == 4) begin
                EWCar2 = 1'b0;
                NSCar2 = 1'b1;
            end
        end
    endtask

    task automatic test_random();
        int prev, len, prev2, len2;
        logic ew, ns;
        do_reset(1'b0, 1'b0);
        reset2 = 1'b1;
        step();
        reset2 = 1'b0;
        prev  = int'(phase);
        len   = 1;
        prev2 = int'(phase2);
        len2  = 1;
        for (int c = 0; c < 10000; c++) begin
            ew = 1'($urandom_range(0, 1));
            ns = 1'($urandom_range(0, 1));
            EWCar  = ew;
            NSCar  = ns;
            EWCar2 = ew;
            NSCar2 = ns;
            step();
            total++;
            if (NSLite !== 3'b100 && EWLite !== 3'b100) begin
                bad++;
                $display("FAIL rnd_both_lit cyc=%0d ns=%b ew=%b want at least one 100", c, NSLite, EWLite);
            end
            total++;
            if (!(NSLite === 3'b001 || NSLite === 3'b010 || NSLite === 3'b100) ||
                !(EWLite === 3'b001 || EWLite === 3'b010 || EWLite === 3'b100)) begin
                bad++;
                $display("FAIL rnd_onehot cyc=%0d ns=%b ew=%b want one-hot", c, NSLite, EWLite);
            end
            if (int'(phase) == prev) begin
                len++;
            end else begin
                if (prev == 0 || prev == 3) begin
                    total++;
                    if (len < 4) begin
                        bad++;
                        $display("FAIL rnd_green_len cyc=%0d got %0d want >=4", c, len);
                    end
                end
                if (prev == 1 || prev == 4) begin
                    total++;
                    if (len != 2) begin
                        bad++;
                        $display("FAIL rnd_yellow_len cyc=%0d got %0d want 2", c, len);
                    end
                end
                prev = int'(phase);
                len  = 1;
            end
            total++;
            if (phase2 === 3'd2 || phase2 === 3'd5 || phase2 > 3'd5) begin
                bad++;
                $display("FAIL rnd_no_red_phase cyc=%0d got ph=%0d want 0,1,3,4", c, phase2);
            end
            if (int'(phase2) == prev2) begin
                len2++;
            end else begin
                if (prev2 == 1 || prev2 == 4) begin
                    total++;
                    if (len2 != 1) begin
                        bad++;
                        $display("FAIL rnd_yellow1_len cyc=%0d got %0d want 1", c, len2);
                    end
                end
                prev2 = int'(phase2);
                len2  = 1;
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        EWCar  = 1'b0;
        NSCar  = 1'b0;
        reset2 = 1'b1;
        EWCar2 = 1'b0;
        NSCar2 = 1'b0;
        test_reset();
        test_both_busy();
        test_hold_late();
        test_async_reset();
        test_no_red();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Parametrised two-road intersection controller. It extends the basic NS/EW green-swap controller with timed yellow and all-red phases, a minimum green time, and a maximum green time that caps how long a busy road can hold green. Car-sensor inputs are sampled synchronously. The lamp outputs are one-hot {red, yellow, green} per road and drive the lamp drivers directly.

Parameters:
GREEN_MIN, 4, minimum cycles a green phase lasts before it may end.
GREEN_MAX, 8, cycles after which green ends if the other road is waiting, even when own-road cars are present.
YELLOW_CYCLES, 2, cycles spent in each yellow phase.
RED_CYCLES, 1, cycles spent in the all-red clearance phase; 0 skips all-red.
CNT_W, 4, phase timer width.
Legal values: 1 <= GREEN_MIN <= GREEN_MAX <= 2^CNT_W; YELLOW_CYCLES in 1..2^CNT_W; RED_CYCLES in 0..2^CNT_W.

Ports:
clock  input  1  system clock; all state changes on the posedge.
reset  input  1  asynchronous, active-high reset.
EWCar  input  1  car waiting on the east-west road; sampled on the posedge.
NSCar  input  1  car waiting on the north-south road; sampled on the posedge.
NSLite  output  3  NS lamps, one-hot {red, yellow, green} = bits [2:0].
EWLite  output  3  EW lamps, one-hot {red, yellow, green}.
phase  output  3  current state encoding, for debug and verification.

Behaviour:
- States and phase codes: NS_GREEN=0, NS_YELLOW=1, NS_RED_CLR=2, EW_GREEN=3, EW_YELLOW=4, EW_RED_CLR=5. Codes 6 and 7 are illegal and go to NS_GREEN on the next edge.
- Reset (async assert, held any time, including mid-phase):
  - state=NS_GREEN, timer=0.
  - NSLite=3'b001, EWLite=3'b100, phase=0.
  - Operation resumes on the first posedge after deassertion.
- Outputs are a pure decode of the state register; there are no combinational paths from EWCar/NSCar.
- Lamp decode:
  - X_GREEN: road X green, other road red.
  - X_YELLOW: road X yellow, other road red.
  - X_RED_CLR: both roads red.
- Timer:
  - Cleared to 0 on every state change, otherwise incremented each cycle.
  - In green states it saturates at GREEN_MAX-1; it never wraps.
  - A state exited at timer==N-1 therefore lasts exactly N cycles.
- NS_GREEN -> NS_YELLOW when EWCar=1 AND either:
  - timer >= GREEN_MIN-1 and NSCar=0, or
  - timer >= GREEN_MAX-1.
  Otherwise stay. With EWCar=0, NS green holds indefinitely.
- EW_GREEN -> EW_YELLOW: same rule with the roles swapped (NSCar is the other-road request, EWCar the own-road demand).
- X_YELLOW -> X_RED_CLR at timer==YELLOW_CYCLES-1.
- If RED_CYCLES=0, X_YELLOW goes directly to the other road's GREEN.
- NS_RED_CLR -> EW_GREEN and EW_RED_CLR -> NS_GREEN at timer==RED_CYCLES-1.
- Yellow and all-red phases ignore the car inputs; no phase is ever aborted.
- Late arrival: if the other-road car arrives after the timer has saturated, green ends on the first edge that samples it, provided the exit condition holds.
- Both cars present continuously: the lights alternate, each green lasting GREEN_MAX cycles.
- Invariant: at no cycle are both roads non-red.

Test Plan:
- Reset held 3 cycles, with EWCar=1 asserted during reset: NSLite=001, EWLite=100, phase=0 throughout. Release reset with EWCar=1, NSCar=0 (defaults): NS green 4 cycles, yellow 2, all-red 1, then EW green (EWLite=001) on the 7th posedge after release.
- EWCar=1, NSCar=1 held: NS green lasts exactly 8 cycles (GREEN_MAX), then 2 yellow, 1 red, EW green for 8 cycles. The sequence repeats with a period of 22 cycles.
- EWCar=0 for 20 cycles, then EWCar=1 for 1 cycle: NS stays green the whole 20 cycles (timer saturated at 7). The single-cycle pulse triggers NS_YELLOW on the next edge.
- Assert reset asynchronously (mid-cycle, not on an edge) during EW_YELLOW: outputs go to NS_GREEN/EW red immediately, without waiting for a clock edge. After release, the NS green minimum restarts from timer 0.
- Build with RED_CYCLES=0, YELLOW_CYCLES=1: NS_YELLOW lasts 1 cycle and then goes straight to EW_GREEN. Phase codes 2 and 5 never appear.
- Random EWCar/NSCar for 10k cycles: a checker confirms no both-non-red cycle, exactly one lamp lit per road, and green duration in [GREEN_MIN, ...] when exited. It also confirms yellow is exactly YELLOW_CYCLES cycles.
